// File: rtl/cmult_requant.sv
// Requantiser behind the CSD twiddle multiplier: strips the 2^SHIFT coefficient scale with
// round-half-to-even, saturates each component to NBITS and tracks saturation events.
module cmult_requant #(
    parameter int NBITS      = 12,
    parameter int NBITScoeff = 11,
    parameter int NBITS_out  = NBITS + NBITScoeff + 1,
    parameter int SHIFT      = NBITScoeff - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NBITS_out*2-1:0]   product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NBITS*2-1:0]       muestra_out,
    input  logic                     clr_stats,
    output logic [15:0]              sat_count,
    output logic                     sat_flag
);

    // One extra bit over the floor quotient so rounding up the largest q cannot wrap.
    localparam int RW = NBITS_out - SHIFT + 1;
    localparam logic [SHIFT-1:0]      HALF = SHIFT'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0]  MAXV = RW'(2**(NBITS-1) - 1);
    localparam logic signed [RW-1:0]  MINV = ~MAXV;

    logic                  v1, v2, sat2;
    logic signed [RW-1:0]  re1, im1;
    logic                  load1, load2;
    logic                  re_hi, re_lo, im_hi, im_lo;
    logic [NBITS-1:0]      re_s, im_s;
    logic                  out_xfer;

    // The upper bits of x are already the floor quotient; the low SHIFT bits decide the rounding.
    function automatic logic signed [RW-1:0] round_conv(input logic [NBITS_out-1:0] x);
        logic [SHIFT-1:0] r;
        logic             up;
        r  = x[SHIFT-1:0];
        up = (r > HALF) || ((r == HALF) && x[SHIFT]);
        return {x[NBITS_out-1], x[NBITS_out-1:SHIFT]} + {{(RW-1){1'b0}}, up};
    endfunction

    assign load2     = !v2 || out_ready;
    assign load1     = !v1 || load2;
    assign in_ready  = load1;
    assign out_valid = v2;
    assign out_xfer  = v2 && out_ready;

    always_comb begin
        re_hi = re1 > MAXV;
        re_lo = re1 < MINV;
        im_hi = im1 > MAXV;
        im_lo = im1 < MINV;
        re_s  = re1[NBITS-1:0];
        im_s  = im1[NBITS-1:0];
        if (re_hi) re_s = MAXV[NBITS-1:0];
        else if (re_lo) re_s = MINV[NBITS-1:0];
        if (im_hi) im_s = MAXV[NBITS-1:0];
        else if (im_lo) im_s = MINV[NBITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            re1 <= '0;
            im1 <= '0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                re1 <= round_conv(product[NBITS_out*2-1:NBITS_out]);
                im1 <= round_conv(product[NBITS_out-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2          <= 1'b0;
            muestra_out <= '0;
            sat2        <= 1'b0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                muestra_out <= {re_s, im_s};
                sat2        <= re_hi || re_lo || im_hi || im_lo;
            end
        end
    end

    // Clear wins over a coincident saturated transfer.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sat_count <= '0;
            sat_flag  <= 1'b0;
        end else if (out_xfer && sat2) begin
            sat_flag <= 1'b1;
            if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cmult_requant.sv
// Directed bench for cmult_requant: rounding, saturation, backpressure, statistics edges
// and mid-stream reset, with hand-computed expectations.
module tb_cmult_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] muestra_out;
    logic        clr_stats;
    logic [15:0] sat_count;
    logic        sat_flag;

    int checks = 0;
    int errors = 0;

    cmult_requant dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .out_valid(out_valid), .out_ready(out_ready), .muestra_out(muestra_out),
        .clr_stats(clr_stats), .sat_count(sat_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] prod(input int re, input int im);
        logic [31:0] a, b;
        a = re;
        b = im;
        return {a[23:0], b[23:0]};
    endfunction

    function automatic logic [23:0] word(input int re, input int im);
        logic [31:0] a, b;
        a = re;
        b = im;
        return {a[11:0], b[11:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the clock edge.
    task automatic applyStimulus(input logic v, input logic [47:0] p, input logic ordy, input logic clr);
        in_valid  = v;
        product   = p;
        out_ready = ordy;
        clr_stats = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [47:0] bprod [6];
        logic [23:0] bexp [6];
        logic        acc;
        int          idx, oidx;

        rst = 1'b1;
        in_valid = 1'b1;
        product = prod(512256, 512768);
        out_ready = 1'b1;
        clr_stats = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_muestra", muestra_out, 0);
        checkOutput("rst_sat_count", sat_count, 0);
        checkOutput("rst_sat_flag", sat_flag, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Rounding: ties go to even, above-half rounds up.
        applyStimulus(1, prod(512256, 512768), 1, 0);
        checkOutput("rnd_lat0", out_valid, 0);
        applyStimulus(1, prod(-1792, -1791), 1, 0);
        checkOutput("rnd1_valid", out_valid, 1);
        checkOutput("rnd1_data", muestra_out, word(1000, 1002));
        applyStimulus(1, prod(2047*512 + 100, -5*512), 1, 0);
        checkOutput("rnd2_data", muestra_out, word(-4, -3));
        applyStimulus(0, '0, 1, 0);
        checkOutput("rnd3_data", muestra_out, word(2047, -5));
        checkOutput("rnd3_count", sat_count, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("rnd_drain", out_valid, 0);

        // Saturation, including a rounded-up value that crosses the limit and exact limits.
        applyStimulus(1, prod(2048*512, -2049*512), 1, 0);
        applyStimulus(1, prod(2047*512 + 300, 0), 1, 0);
        checkOutput("sat1_data", muestra_out, word(2047, -2048));
        checkOutput("sat1_count_pre", sat_count, 0);
        applyStimulus(1, prod(-2048*512 - 256, 2047*512 + 255), 1, 0);
        checkOutput("sat2_data", muestra_out, word(2047, 0));
        checkOutput("sat1_count", sat_count, 1);
        checkOutput("sat1_flag", sat_flag, 1);
        applyStimulus(0, '0, 1, 0);
        checkOutput("edge_data", muestra_out, word(-2048, 2047));
        checkOutput("sat2_count", sat_count, 2);
        applyStimulus(0, '0, 1, 0);
        checkOutput("edge_count", sat_count, 2);
        checkOutput("edge_drain", out_valid, 0);

        // Backpressure: four stalled cycles, then drain.
        for (int k = 0; k < 6; k++) begin
            bprod[k] = prod((k + 1) * 512, -(k + 1) * 512);
            bexp[k]  = word(k + 1, -(k + 1));
        end
        idx = 0;
        oidx = 0;
        for (int cyc = 0; cyc < 40 && oidx < 6; cyc++) begin
            in_valid  = (idx < 6);
            product   = (idx < 6) ? bprod[idx] : '0;
            out_ready = (cyc >= 4);
            clr_stats = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (cyc == 3) begin
                checkOutput("bp_accepted", idx, 2);
                checkOutput("bp_in_ready_low", in_ready, 0);
            end
            if (out_valid) begin
                checkOutput("bp_data", muestra_out, bexp[oidx]);
                if (out_ready) oidx++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        checkOutput("bp_all_out", oidx, 6);
        checkOutput("bp_all_in", idx, 6);
        applyStimulus(0, '0, 1, 0);
        checkOutput("bp_drain", out_valid, 0);

        // Counter saturation at 0xFFFF, then clear coincident with a saturated transfer.
        for (int n = 0; n < 70000 && sat_count != 16'hFFFF; n++)
            applyStimulus(1, prod(4000*512, 0), 1, 0);
        checkOutput("preload_reached", sat_count, 16'hFFFF);
        applyStimulus(0, '0, 1, 0);
        checkOutput("count_hold", sat_count, 16'hFFFF);
        checkOutput("count_hold_valid", out_valid, 1);
        applyStimulus(0, '0, 1, 1);
        checkOutput("clr_count", sat_count, 0);
        checkOutput("clr_flag", sat_flag, 0);
        checkOutput("clr_valid", out_valid, 0);

        // Reset with both stages full.
        applyStimulus(1, prod(10*512, 11*512), 1, 0);
        applyStimulus(1, prod(12*512, 13*512), 0, 0);
        checkOutput("mid_full", out_valid, 1);
        checkOutput("mid_full_data", muestra_out, word(10, 11));
        rst = 1'b1;
        applyStimulus(1, prod(14*512, 15*512), 0, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", muestra_out, 0);
        rst = 1'b0;
        applyStimulus(1, prod(-7*512, 7*512), 1, 0);
        checkOutput("mid_lat1", out_valid, 0);
        applyStimulus(0, '0, 1, 0);
        checkOutput("mid_lat2_valid", out_valid, 1);
        checkOutput("mid_lat2_data", muestra_out, word(-7, 7));
        applyStimulus(0, '0, 1, 0);
        checkOutput("mid_drain", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmult_requant.md
Name: cmult_requant

Overview:
- Back end of the twiddle multiplier interface.
- Accepts packed complex products {real, imag}, each NBITS_out bits wide, from the CSD constant multiplier.
- Removes the coefficient scale 2^SHIFT with convergent rounding, saturates each component back to NBITS, and returns packed NBITS samples to the next FFT stage.
- Two-stage valid/ready pipeline, plus saturation statistics for overflow monitoring.

Parameters:
- NBITS, 12, output sample component width (signed).
- NBITScoeff, 11, coefficient width; sets the default scale.
- NBITS_out, NBITS+NBITScoeff+1, input product component width (signed).
- SHIFT, NBITScoeff-2, right shift that removes the coefficient scale (unity coefficient = 2^SHIFT). Must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product word valid.
- in_ready  output  1  block can accept the product word this cycle.
- product  input  NBITS_out*2  packed {real[NBITS_out*2-1:NBITS_out], imag[NBITS_out-1:0]}, signed.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- muestra_out  output  NBITS*2  packed {real, imag}, signed, NBITS each.
- clr_stats  input  1  synchronous clear of sat_count and sat_flag.
- sat_count  output  16  number of transferred outputs with at least one saturated component.
- sat_flag  output  1  sticky: any saturation since reset/clear.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out_valid=0, muestra_out=0, sat_count=0, sat_flag=0, both stage-valid bits=0. in_ready is 1 in the cycle after reset.
- Transfer rules: input transfers when in_valid && in_ready; output transfers when out_valid && out_ready.
- Stage 1 (round): per component, x is a signed NBITS_out-bit value.
  - q = x >>> SHIFT (floor); r = x[SHIFT-1:0]; half = 2^(SHIFT-1).
  - Rounded value = q+1 if r>half, or if r==half and q is odd; otherwise q. This is round-half-to-even.
  - Result is held in NBITS_out-SHIFT+1 bits, so +1 on the maximum q does not wrap.
- Stage 2 (saturate): clamp each component to [-2^(NBITS-1), 2^(NBITS-1)-1].
  - Register muestra_out and a per-word sat bit = real clamped OR imag clamped.
- Stall logic:
  - Stage 2 loads when !v2 || out_ready.
  - Stage 1 loads when !v1 || stage-2 load.
  - in_ready = !v1 || !v2 || out_ready (combinational from out_ready and the valid bits).
- Latency: 2 cycles from accepted input to out_valid with no stall. Throughput: 1 word/cycle.
- Order is preserved. No word is dropped or duplicated under any out_ready pattern.
- muestra_out and out_valid hold stable while out_valid && !out_ready.
- Statistics:
  - On an output transfer of a word with sat bit set, sat_count increments, saturating at 0xFFFF (no wrap), and sat_flag is set.
  - clr_stats has priority over a simultaneous increment: the result is count=0 and flag=0.
- rst mid-stream: all in-flight words are discarded; out_valid=0 on the next cycle.
- in_valid while !in_ready: the word is not consumed. The upstream holds it.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> out_valid=0, muestra_out=0, sat_count=0, in_ready=1 after release.
- Rounding (SHIFT=9): real=512256 (1000.5), imag=512768 (1001.5) -> {1000, 1002} two cycles later. real=-1792 (-3.5), imag=-1791 -> {-4, -3}. real=2047*512+100, imag=-5*512 -> {2047, -5}.
- Saturation: real=2048*512, imag=-2049*512 -> {2047, -2048}, sat_count=1, sat_flag=1. real=2047*512+300 rounds to 2048 -> 2047, sat_count=2.
- Backpressure: stream 6 words with out_ready=0 for 4 cycles -> in_ready falls after 2 words accepted, out_valid/muestra_out hold the first word; after out_ready=1 all 6 words emerge in order, none lost.
- Stats edges: preload 65535 saturating transfers -> sat_count stays 0xFFFF on the next. clr_stats coincident with a saturated transfer -> sat_count=0, sat_flag=0.
- Reset mid-stream: rst asserted with both stages full -> next cycle out_valid=0. The following input appears after exactly 2 cycles.
